// File: rtl/clock_divider_prog.sv
// Programmable integer clock divider with glitch-free registered outputs.
// Divisor changes are staged and only take effect on a period boundary,
// so every o_clk period is a complete period of a single divisor.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV_DEFAULT = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic [WIDTH-1:0] o_div,
  output logic             o_pending,
  output logic             o_err
);

  localparam int unsigned     HW      = WIDTH + 1;
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DIV_DEFAULT - 1);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] div_q,  div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_q,  clk_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;
  logic             err_q,  err_d;

  logic [WIDTH-1:0] cnt_last_c;
  logic [WIDTH-1:0] cnt_next_c;
  logic [HW-1:0]    high_c;
  logic             wrap_c;
  logic             load_ok_c;
  logic             load_bad_c;

  // Period bookkeeping: wrap point, next count and high-time of the active divisor.
  // High-time is computed one bit wider so (div+1) cannot overflow at 2^WIDTH-1.
  always_comb begin
    cnt_last_c = div_q - ONE;
    wrap_c     = i_enable && (cnt_q == cnt_last_c);
    cnt_next_c = wrap_c ? '0 : (cnt_q + ONE);
    high_c     = ({1'b0, div_q} + HW'(1)) >> 1;
    load_ok_c  = i_load && (i_div >= DIV_MIN);
    load_bad_c = i_load && (i_div <  DIV_MIN);
  end

  // Next-state: counting, divisor staging and application at the wrap edge.
  always_comb begin
    cnt_d     = cnt_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    div_d     = div_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    err_d     = load_bad_c;

    if (i_enable) begin
      cnt_d  = cnt_next_c;
      clk_d  = ({1'b0, cnt_next_c} < high_c);
      tick_d = wrap_c;
    end

    if (load_ok_c) begin
      if (wrap_c) begin
        // Load landing on the boundary goes straight into the new period.
        div_d     = i_div;
        pend_d    = i_div;
        pending_d = 1'b0;
      end else begin
        pend_d    = i_div;
        pending_d = 1'b1;
      end
    end else if (wrap_c && pending_q) begin
      div_d     = pend_q;
      pending_d = 1'b0;
    end
  end

  // State register; reset discards any staged divisor and the partial period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= CNT_RST;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      div_q     <= DIV_RST;
      pend_q    <= DIV_RST;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign o_clk     = clk_q;
  assign o_tick    = tick_q;
  assign o_div     = div_q;
  assign o_pending = pending_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: a behavioural cycle model predicts
// the outputs for each edge, the prediction is queued when inputs are driven
// and compared just after the edge.
module tb_clock_divider_prog;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIVD  = 10;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_enable;
  logic             i_load;
  logic [WIDTH-1:0] i_div;
  logic             o_clk;
  logic             o_tick;
  logic [WIDTH-1:0] o_div;
  logic             o_pending;
  logic             o_err;

  typedef struct {
    int clk;
    int tick;
    int div;
    int pend;
    int err;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  int m_cnt, m_div, m_clk, m_pend, m_pval;
  int ticks_seen, errs_seen;

  clock_divider_prog #(.WIDTH(WIDTH), .DIV_DEFAULT(DIVD)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_load   (i_load),
    .i_div    (i_div),
    .o_clk    (o_clk),
    .o_tick   (o_tick),
    .o_div    (o_div),
    .o_pending(o_pending),
    .o_err    (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = DIVD - 1;
    m_div  = DIVD;
    m_clk  = 0;
    m_pend = 0;
    m_pval = DIVD;
    exp_q.delete();
  endtask

  // Predict outputs after the coming edge from the currently driven inputs.
  task automatic model_push();
    exp_t e;
    int   nxt;
    int   hi;
    bit   wrap;
    bit   ok;
    wrap   = (i_enable == 1'b1) && (m_cnt == m_div - 1);
    ok     = (i_load == 1'b1) && (int'(i_div) >= 2);
    e.err  = ((i_load == 1'b1) && (int'(i_div) < 2)) ? 1 : 0;
    e.tick = 0;
    if (i_enable == 1'b1) begin
      hi     = (m_div + 1) / 2;
      nxt    = wrap ? 0 : m_cnt + 1;
      m_clk  = (nxt < hi) ? 1 : 0;
      e.tick = (nxt == 0) ? 1 : 0;
      m_cnt  = nxt;
    end
    if (ok) begin
      if (wrap) begin
        m_div  = int'(i_div);
        m_pend = 0;
      end else begin
        m_pval = int'(i_div);
        m_pend = 1;
      end
    end else if (wrap && m_pend == 1) begin
      m_div  = m_pval;
      m_pend = 0;
    end
    e.clk  = m_clk;
    e.div  = m_div;
    e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  // One clock: queue prediction, let the edge happen, compare after it.
  task automatic step(input logic en, input logic ld, input int dv);
    exp_t e;
    i_enable = en;
    i_load   = ld;
    i_div    = WIDTH'(dv);
    model_push();
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("o_clk",     int'(o_clk),     e.clk);
      chk("o_tick",    int'(o_tick),    e.tick);
      chk("o_div",     int'(o_div),     e.div);
      chk("o_pending", int'(o_pending), e.pend);
      chk("o_err",     int'(o_err),     e.err);
      if (o_tick) ticks_seen++;
      if (o_err)  errs_seen++;
    end
    i_load = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk"},  int'(o_clk),     0);
    chk({tag, "_tick"}, int'(o_tick),    0);
    chk({tag, "_div"},  int'(o_div),     DIVD);
    chk({tag, "_pend"}, int'(o_pending), 0);
    chk({tag, "_err"},  int'(o_err),     0);
  endtask

  // Advance enabled until the next edge is a wrap edge.
  task automatic run_to_wrap_edge();
    int guard;
    guard = 0;
    while ((m_cnt != m_div - 1) && guard < 300) begin
      step(1'b1, 1'b0, 0);
      guard++;
    end
    if (guard >= 300) chk("wrap_timeout", guard, 0);
  endtask

  initial begin
    int tick_at[$];
    i_rst_n  = 1'b0;
    i_enable = 1'b0;
    i_load   = 1'b0;
    i_div    = '0;
    ticks_seen = 0;
    errs_seen  = 0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_vals("reset");
    #3 i_rst_n = 1'b1;

    // Default divisor: ticks on enabled edges 1, 11, 21.
    for (int k = 1; k <= 25; k++) begin
      step(1'b1, 1'b0, 0);
      if (o_tick) tick_at.push_back(k);
    end
    chk("default_ticks", tick_at.size(), 3);
    if (tick_at.size() == 3) begin
      chk("tick_edge_a", tick_at[0], 1);
      chk("tick_edge_b", tick_at[1], 11);
      chk("tick_edge_c", tick_at[2], 21);
    end

    // Odd divisor loaded mid-period.
    step(1'b1, 1'b1, 7);
    chk("pending_after_load", int'(o_pending), 1);
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 0);
    chk("div_now_7", int'(o_div), 7);

    // Load landing exactly on the wrap edge.
    run_to_wrap_edge();
    step(1'b1, 1'b1, 4);
    chk("wrap_load_no_pending", int'(o_pending), 0);
    chk("wrap_load_div", int'(o_div), 4);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 0);

    // Illegal loads back to back.
    errs_seen = 0;
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    chk("err_pulses", errs_seen, 2);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 0);

    // Freeze for three cycles inside the high phase, with a load while frozen.
    run_to_wrap_edge();
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 5);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    chk("frozen_high", int'(o_clk), 1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 0);

    // Pending 6 then asynchronous reset between edges.
    run_to_wrap_edge();
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 6);
    chk("pending6", int'(o_pending), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    model_reset();
    #3 i_rst_n = 1'b1;
    for (int k = 0; k < 25; k++) step(1'b1, 1'b0, 0);
    chk("post_reset_div", int'(o_div), DIVD);

    // Random mix of enable, loads and illegal divisors.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
